fu_mult: RTL and testbench

FU_MULT -- requirements
Module: fu_mult

---
 rtl/fu_mult.sv | 135 +++++++++++++
 tb/tb_fu_mult.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fu_mult.sv
// Pipelined integer multiplier unit (MUL/MULH/MULHSU/MULHU) feeding the CDB.
// Ports: clock/reset (sync, active-high), RS issue (in_*), squash flush,
// avail to the RS, and a CDB request/grant handshake (cdb_*).
`timescale 1ns/1ps
module fu_mult #(
  parameter int XLEN   = 32,
  parameter int STAGES = 4,
  parameter int PRN_W  = 6,
  parameter int ROBN_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [1:0]        in_func,
  input  logic [XLEN-1:0]   in_op1,
  input  logic [XLEN-1:0]   in_op2,
  input  logic [PRN_W-1:0]  in_dest_prn,
  input  logic [ROBN_W-1:0] in_robn,
  input  logic              squash,
  input  logic              cdb_grant,
  output logic              avail,
  output logic              cdb_req,
  output logic [XLEN-1:0]   cdb_value,
  output logic [PRN_W-1:0]  cdb_dest_prn,
  output logic [ROBN_W-1:0] cdb_robn
);

  localparam int PW   = 2 * XLEN;
  localparam int CW   = (PW + STAGES - 1) / STAGES;
  localparam int LAST = STAGES - 1;

  localparam logic [1:0] F_MUL    = 2'd0;
  localparam logic [1:0] F_MULH   = 2'd1;
  localparam logic [1:0] F_MULHSU = 2'd2;

  // acc holds the sum of the chunks consumed so far; mcand is op1
  // pre-shifted to the next chunk's weight; mplier holds unconsumed op2.
  typedef struct packed {
    logic              valid;
    logic [1:0]        func;
    logic [PRN_W-1:0]  prn;
    logic [ROBN_W-1:0] robn;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     mcand;
    logic [PW-1:0]     mplier;
  } slot_t;

  slot_t slot [STAGES];
  slot_t nxt  [STAGES];

  logic [STAGES-1:0] adv;
  logic              hole;
  logic              accept;
  logic              sgn1;
  logic              sgn2;
  logic [PW-1:0]     a;
  logic [PW-1:0]     b;

  function automatic logic [PW-1:0] pp(
    input logic [PW-1:0] m,
    input logic [CW-1:0] c
  );
    return m * {{(PW-CW){1'b0}}, c};
  endfunction

  // A slot may move when some later slot is empty or the tail is granted.
  always_comb begin
    adv  = '0;
    hole = !slot[LAST].valid || cdb_grant;
    adv[LAST] = hole;
    for (int i = LAST - 1; i >= 0; i--) begin
      hole   = hole || !slot[i+1].valid;
      adv[i] = hole;
    end
  end

  assign avail  = !slot[0].valid || adv[0];
  assign accept = in_valid && avail && !squash;

  // Signed operands are extended to 2*XLEN so a plain modular product of
  // the extended values yields the correct high half for every variant.
  always_comb begin
    sgn1 = (in_func == F_MULH) || (in_func == F_MULHSU);
    sgn2 = (in_func == F_MULH);
    a = {{XLEN{sgn1 & in_op1[XLEN-1]}}, in_op1};
    b = {{XLEN{sgn2 & in_op2[XLEN-1]}}, in_op2};
    nxt[0] = '0;
    if (accept) begin
      nxt[0].valid  = 1'b1;
      nxt[0].func   = in_func;
      nxt[0].prn    = in_dest_prn;
      nxt[0].robn   = in_robn;
      nxt[0].acc    = pp(a, b[CW-1:0]);
      nxt[0].mcand  = a << CW;
      nxt[0].mplier = b >> CW;
    end
    for (int i = 1; i < STAGES; i++) begin
      nxt[i]        = slot[i-1];
      nxt[i].acc    = slot[i-1].acc
                    + pp(slot[i-1].mcand, slot[i-1].mplier[CW-1:0]);
      nxt[i].mcand  = slot[i-1].mcand << CW;
      nxt[i].mplier = slot[i-1].mplier >> CW;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++)
        slot[i] <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++)
        if (adv[i]) slot[i] <= nxt[i];
      if (squash)
        for (int i = 0; i < STAGES; i++)
          slot[i].valid <= 1'b0;
    end
  end

  assign cdb_req = slot[LAST].valid;

  always_comb begin
    cdb_value    = '0;
    cdb_dest_prn = '0;
    cdb_robn     = '0;
    if (cdb_req) begin
      cdb_dest_prn = slot[LAST].prn;
      cdb_robn     = slot[LAST].robn;
      if (slot[LAST].func == F_MUL)
        cdb_value = slot[LAST].acc[XLEN-1:0];
      else
        cdb_value = slot[LAST].acc[PW-1:XLEN];
    end
  end

endmodule

// File: tb/tb_fu_mult.sv
// Scoreboard bench for fu_mult: issue pushes hand-computed results,
// a negedge monitor pops them as the CDB transfers.
`timescale 1ns/1ps
module tb_fu_mult;

  localparam int XLEN   = 32;
  localparam int STAGES = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  in_func = '0;
  logic [31:0] in_op1 = '0;
  logic [31:0] in_op2 = '0;
  logic [5:0]  in_dest_prn = '0;
  logic [4:0]  in_robn = '0;
  logic        squash = 1'b0;
  logic        cdb_grant = 1'b0;
  logic        avail;
  logic        cdb_req;
  logic [31:0] cdb_value;
  logic [5:0]  cdb_dest_prn;
  logic [4:0]  cdb_robn;

  fu_mult #(.XLEN(XLEN), .STAGES(STAGES), .PRN_W(6), .ROBN_W(5)) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_func(in_func),
    .in_op1(in_op1),
    .in_op2(in_op2),
    .in_dest_prn(in_dest_prn),
    .in_robn(in_robn),
    .squash(squash),
    .cdb_grant(cdb_grant),
    .avail(avail),
    .cdb_req(cdb_req),
    .cdb_value(cdb_value),
    .cdb_dest_prn(cdb_dest_prn),
    .cdb_robn(cdb_robn)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] v;
    logic [5:0]  p;
    logic [4:0]  r;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: pops on every CDB transfer and checks stall stability.
  logic        hold_prev = 1'b0;
  logic [43:0] prev_out  = '0;
  always @(negedge clock) begin
    if (reset || squash) begin
      sb.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev)
        check("stall_hold", {20'd0, cdb_req, cdb_value, cdb_dest_prn, cdb_robn},
              {20'd0, prev_out});
      if (cdb_req && cdb_grant) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got %h want none", cdb_value);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("cdb_result", {21'd0, cdb_value, cdb_dest_prn, cdb_robn},
                {21'd0, e});
        end
      end
      hold_prev = cdb_req && !cdb_grant;
      prev_out  = {cdb_req, cdb_value, cdb_dest_prn, cdb_robn};
    end
  end

  task automatic issue(input logic [1:0] f, input logic [31:0] x,
                       input logic [31:0] y, input logic [5:0] p,
                       input logic [4:0] r, input logic [31:0] e,
                       output bit acc);
    in_valid    = 1'b1;
    in_func     = f;
    in_op1      = x;
    in_op2      = y;
    in_dest_prn = p;
    in_robn     = r;
    @(negedge clock);
    acc = avail;
    @(posedge clock);
    if (acc) sb.push_back({e, p, r});
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clock);
      n++;
    end
    #1;
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  bit acc;

  initial begin
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_req",   64'(cdb_req),      64'd0);
    check("rst_avail", 64'(avail),        64'd1);
    check("rst_value", 64'(cdb_value),    64'd0);
    check("rst_prn",   64'(cdb_dest_prn), 64'd0);
    check("rst_robn",  64'(cdb_robn),     64'd0);
    @(posedge clock);
    #1;

    // Basic MUL with latency and single-cycle presentation.
    cdb_grant = 1'b1;
    issue(2'd0, 32'd7, 32'd6, 6'd5, 5'd3, 32'd42, acc);
    for (int k = 1; k <= STAGES + 1; k++) begin
      @(negedge clock);
      check("latency_req", 64'(cdb_req), 64'(k == STAGES));
    end
    @(posedge clock);
    #1;

    // High-half variants back to back.
    issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd10, 5'd1, 32'h00000000, acc);
    issue(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd11, 5'd2, 32'hFFFFFFFE, acc);
    issue(2'd2, 32'hFFFFFFFF, 32'd2,        6'd12, 5'd3, 32'hFFFFFFFF, acc);
    issue(2'd0, 32'h80000000, 32'd2,        6'd13, 5'd4, 32'h00000000, acc);
    drain();

    // Back-pressure: pipe fills, fifth issue is refused.
    cdb_grant = 1'b0;
    issue(2'd0, 32'd3,        32'd4,        6'd20, 5'd5, 32'd12,        acc);
    check("bp_acc0", 64'(acc), 64'd1);
    issue(2'd0, 32'd5,        32'd5,        6'd21, 5'd6, 32'd25,        acc);
    check("bp_acc1", 64'(acc), 64'd1);
    issue(2'd0, 32'hFFFFFFFF, 32'd3,        6'd22, 5'd7, 32'hFFFFFFFD,  acc);
    check("bp_acc2", 64'(acc), 64'd1);
    issue(2'd3, 32'h00010000, 32'h00010000, 6'd23, 5'd8, 32'h00000001,  acc);
    check("bp_acc3", 64'(acc), 64'd1);
    issue(2'd1, 32'h80000000, 32'h80000000, 6'd24, 5'd9, 32'h40000000,  acc);
    check("bp_acc4_full", 64'(acc), 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("bp_hold_req",   64'(cdb_req),   64'd1);
    check("bp_hold_value", 64'(cdb_value), 64'd12);
    @(posedge clock);
    #1;

    // Full-pipe pass-through: grant and issue in the same cycle.
    cdb_grant = 1'b1;
    issue(2'd1, 32'h80000000, 32'h80000000, 6'd24, 5'd9,  32'h40000000, acc);
    check("pass_acc4", 64'(acc), 64'd1);
    issue(2'd2, 32'h80000000, 32'h80000000, 6'd25, 5'd10, 32'hC0000000, acc);
    check("pass_acc5", 64'(acc), 64'd1);
    drain();

    // Squash with the oldest op presenting and granted.
    issue(2'd0, 32'd2, 32'd3, 6'd30, 5'd11, 32'd6,  acc);
    issue(2'd0, 32'd2, 32'd4, 6'd31, 5'd12, 32'd8,  acc);
    issue(2'd0, 32'd2, 32'd5, 6'd32, 5'd13, 32'd10, acc);
    @(posedge clock);
    #1;
    squash   = 1'b1;
    in_valid = 1'b1;
    in_func  = 2'd0;
    in_op1   = 32'd11;
    in_op2   = 32'd11;
    @(negedge clock);
    check("sq_presenting", 64'(cdb_req), 64'd1);
    @(posedge clock);
    #1;
    squash   = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    check("sq_req",   64'(cdb_req), 64'd0);
    check("sq_avail", 64'(avail),   64'd1);
    @(posedge clock);
    #1;
    issue(2'd0, 32'd9, 32'd9, 6'd33, 5'd14, 32'd81, acc);
    check("sq_after_acc", 64'(acc), 64'd1);
    drain();

    // Mid-operation reset with two ops in flight.
    issue(2'd0, 32'd100, 32'd100, 6'd40, 5'd15, 32'd10000, acc);
    issue(2'd3, 32'd7,   32'd7,   6'd41, 5'd16, 32'd0,     acc);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int k = 0; k < STAGES + 2; k++) begin
      @(negedge clock);
      check("mrst_req",   64'(cdb_req),   64'd0);
      check("mrst_value", 64'(cdb_value), 64'd0);
    end
    check("mrst_avail", 64'(avail), 64'd1);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
